// File: rtl/buffer_arbiter.sv
// buffer_arbiter: round-robin burst-limited write arbiter and registered read stage for the shared Buffer FIFO
module buffer_arbiter #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             grant0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             grant1,
  output logic             buf_write,
  output logic [WIDTH-1:0] buf_data_in,
  input  logic             buf_full,
  output logic             buf_read,
  input  logic             buf_empty,
  input  logic [WIDTH-1:0] buf_data_out,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  localparam logic [3:0] CNT_MAX = 4'(BURST_LEN - 1);
  state_t     state, state_nxt;
  logic       prio, pick1, grant_ok, read_nxt;
  logic [3:0] burst_cnt;
  always_comb begin
    pick1       = (req0 & req1) ? ((burst_cnt == CNT_MAX) ? ~prio : prio) : req1;
    grant_ok    = rst & ~buf_full & (req0 | req1);
    grant0      = grant_ok & ~pick1;
    grant1      = grant_ok & pick1;
    buf_write   = grant0 | grant1;
    buf_data_in = grant1 ? data1 : data0;
  end
  // burst_cnt counts consecutive grants to prio, saturating so the hand-off test stays true
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio      <= 1'b0;
      burst_cnt <= '0;
    end else if (buf_write) begin
      if (pick1 == prio) begin
        burst_cnt <= (burst_cnt == CNT_MAX) ? CNT_MAX : burst_cnt + 4'd1;
      end else begin
        prio      <= pick1;
        burst_cnt <= (CNT_MAX == 4'd0) ? 4'd0 : 4'd1;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    read_nxt  = 1'b0;
    case (state)
      IDLE: begin
        read_nxt  = ~buf_empty;
        state_nxt = buf_empty ? IDLE : FETCH;
      end
      FETCH: state_nxt = HOLD;
      HOLD: begin
        read_nxt  = out_ready & ~buf_empty;
        state_nxt = !out_ready ? HOLD : (buf_empty ? IDLE : FETCH);
      end
      default: state_nxt = IDLE;
    endcase
    buf_read = rst & read_nxt;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == HOLD);
      if (state == FETCH) out_data <= buf_data_out;
    end
  end
endmodule
